dds_wave_gen: RTL and testbench



---
 rtl/dds_wave_gen.sv | 146 ++++++++++++++
 tb/tb_dds_wave_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// Direct-digital-synthesis tone generator: phase accumulator, quarter-wave sine
// table mirrored by quadrant, plus triangle/sawtooth/square, 2-stage output pipe.
module dds_wave_gen #(
  parameter int PHASE_W   = 16,
  parameter int ADDR_W    = 8,
  parameter int OUT_W     = 8,
  parameter int AMPLITUDE = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PHASE_W-1:0] ftw,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [2:0]         mode,
  output logic [OUT_W-1:0]   sample_o,
  output logic               valid_o,
  output logic [PHASE_W-1:0] phase_o
);

  localparam int  N     = 2 ** (ADDR_W - 2);
  localparam int  AMP_W = $clog2(AMPLITUDE + 1);
  localparam int  PW    = ADDR_W + AMP_W;
  localparam real PI    = 3.14159265358979323846;

  localparam logic [ADDR_W-2:0]   N_IDX = {1'b1, {(ADDR_W-2){1'b0}}};
  localparam logic [ADDR_W-1:0]   QTR   = {2'b01, {(ADDR_W-2){1'b0}}};
  localparam logic [OUT_W-1:0]    AMP_O = OUT_W'(AMPLITUDE);
  localparam logic [PW-1:0]       AMP_P = PW'(AMPLITUDE);
  localparam logic signed [PW:0]  AMP_S = (PW+1)'(AMPLITUDE);

  localparam logic [2:0] M_SIN = 3'd0;
  localparam logic [2:0] M_COS = 3'd1;
  localparam logic [2:0] M_TRI = 3'd2;
  localparam logic [2:0] M_SAW = 3'd3;
  localparam logic [2:0] M_SQR = 3'd4;

  if (ADDR_W < 3 || ADDR_W > PHASE_W || AMPLITUDE > 2 ** (OUT_W - 1) - 1) begin : g_param_err
    $error("dds_wave_gen: illegal ADDR_W/PHASE_W/AMPLITUDE/OUT_W combination");
  end

  // First-quadrant entries are non-negative, so +0.5 then truncation rounds half away from zero.
  function automatic logic [OUT_W-1:0] sine_entry(input int k);
    real x;
    x = real'(AMPLITUDE) * $sin(2.0 * PI * real'(k) / real'(4 * N));
    return OUT_W'($rtoi(x + 0.5));
  endfunction

  logic [OUT_W-1:0] tbl_s [0:N];

  for (genvar k = 0; k <= N; k++) begin : g_tbl
    assign tbl_s[k] = sine_entry(k);
  end

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [2:0]         mode_q, mode_d;
  logic               v1_q, v1_d;
  logic [OUT_W-1:0]   sample_q, sample_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  addr_raw_s;

  // Accumulator and stage 1: address uses the accumulator value before this edge's update.
  always_comb begin
    acc_d      = acc_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    v1_d       = 1'b0;
    addr_raw_s = ADDR_W'((acc_q + phase_off) >> (PHASE_W - ADDR_W));
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d  = acc_q + ftw;
      mode_d = mode;
      v1_d   = 1'b1;
      if (mode == M_COS) begin
        addr_d = addr_raw_s + QTR;
      end else begin
        addr_d = addr_raw_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  logic [1:0]        quad_s;
  logic [ADDR_W-3:0] r_s;
  logic [ADDR_W-2:0] idx_s;
  logic [OUT_W-1:0]  sine_mag_s;
  logic [PW-1:0]     tri_prod_s;
  logic [OUT_W-1:0]  tri_l_s;
  logic [OUT_W-1:0]  tri_mag_s;
  logic signed [PW:0] saw_prod_s;
  logic [OUT_W-1:0]  wave_s;

  // Stage 2 waveform evaluation; odd quadrants mirror, the upper half negates.
  always_comb begin
    quad_s     = addr_q[ADDR_W-1:ADDR_W-2];
    r_s        = addr_q[ADDR_W-3:0];
    idx_s      = quad_s[0] ? (N_IDX - {1'b0, r_s}) : {1'b0, r_s};
    sine_mag_s = tbl_s[idx_s];
    tri_prod_s = PW'(r_s) * AMP_P;
    tri_l_s    = OUT_W'(tri_prod_s >> (ADDR_W - 2));
    tri_mag_s  = quad_s[0] ? (AMP_O - tri_l_s) : tri_l_s;
    saw_prod_s = (PW+1)'($signed(addr_q)) * AMP_S;
    wave_s     = '0;
    case (mode_q)
      M_SIN, M_COS: wave_s = quad_s[1] ? (-sine_mag_s) : sine_mag_s;
      M_TRI:        wave_s = quad_s[1] ? (-tri_mag_s) : tri_mag_s;
      M_SAW:        wave_s = OUT_W'(saw_prod_s >>> (ADDR_W - 1));
      M_SQR:        wave_s = addr_q[ADDR_W-1] ? (-AMP_O) : AMP_O;
      default:      wave_s = '0;
    endcase
    if (clr) begin
      sample_d = sample_q;
      valid_d  = 1'b0;
    end else begin
      sample_d = wave_s;
      valid_d  = v1_q;
    end
  end

  // State registers for accumulator and both pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      addr_q   <= '0;
      mode_q   <= 3'd0;
      v1_q     <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      addr_q   <= addr_d;
      mode_q   <= mode_d;
      v1_q     <= v1_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign sample_o = sample_q;
  assign valid_o  = valid_q;
  assign phase_o  = acc_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Scoreboard bench for dds_wave_gen: a real-arithmetic reference model queues
// expected samples at issue time; a monitor pops and compares on valid_o.
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] ftw = 16'h0000;
  logic [15:0] phase_off = 16'h0000;
  logic [2:0]  mode = 3'd0;
  logic [7:0]  sample_o;
  logic        valid_o;
  logic [15:0] phase_o;

  int checks = 0;
  int errors = 0;

  dds_wave_gen #(.PHASE_W(16), .ADDR_W(8), .OUT_W(8), .AMPLITUDE(64)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .ftw(ftw),
    .phase_off(phase_off), .mode(mode), .sample_o(sample_o),
    .valid_o(valid_o), .phase_o(phase_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] s;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] cap[$];
  int         cyc = 0;
  int         m_acc = 0;

  function automatic int rnd_away(real v);
    if (v >= 0.0) return $rtoi($floor(v + 0.5));
    else return -$rtoi($floor(-v + 0.5));
  endfunction

  // Reference waveform for a full-cycle address a in 0..255, amplitude 64.
  function automatic logic [7:0] ref_wave(int a, int md);
    real th;
    int  as, r, l, v;
    th = 2.0 * 3.14159265358979 * real'(a) / 256.0;
    r  = a % 64;
    l  = (r * 64) / 64;
    as = (a >= 128) ? a - 256 : a;
    case (md)
      0: v = rnd_away(64.0 * $sin(th));
      1: v = rnd_away(64.0 * $cos(th));
      2: begin
        if (a < 64)       v = l;
        else if (a < 128) v = 64 - l;
        else if (a < 192) v = -l;
        else              v = -(64 - l);
      end
      3: v = $rtoi($floor(real'(as) * 64.0 / 128.0));
      4: v = (a < 128) ? 64 : -64;
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: issues expected samples on every enabled edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_acc = 0;
      sb.delete();
    end else begin
      cyc++;
      if (clr) begin
        sb.delete();
        m_acc = 0;
      end else if (en) begin
        int a;
        a = ((m_acc + int'(phase_off)) % 65536) / 256;
        sb.push_back('{cyc, ref_wave(a, int'(mode))});
        m_acc = (m_acc + int'(ftw)) % 65536;
      end
    end
  end

  // Monitor: valid_o expected exactly one edge after the stage-1 capture.
  initial forever begin
    int exp_v;
    exp_t e;
    @(negedge clk);
    chk("phase_o", int'(phase_o), m_acc);
    while (sb.size() > 0 && sb[0].cyc < cyc - 1) void'(sb.pop_front());
    exp_v = (sb.size() > 0 && sb[0].cyc == cyc - 1) ? 1 : 0;
    chk("valid_o", int'(valid_o), exp_v);
    if (valid_o) begin
      cap.push_back(sample_o);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sample", int'(sample_o), int'(e.s));
      end
    end
  end

  task automatic do_clr();
    @(negedge clk);
    en  = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [15:0] f, input logic [15:0] off, input logic [2:0] md, input int n);
    @(negedge clk);
    ftw       = f;
    phase_off = off;
    mode      = md;
    cap.delete();
    en        = 1'b1;
    repeat (n) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("sample_count", cap.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pat  [6] = '{1, 0, 1, 0, 0, 0};
    int expv [6] = '{0, 1, 0, 1, 0, 0};
    int found;

    repeat (3) @(negedge clk);
    chk("rst_sample", int'(sample_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_phase", int'(phase_o), 0);
    rst_n = 1'b1;

    do_clr();
    ftw = 16'h0100; phase_off = 16'h0000; mode = 3'd0;
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1 chk("lat_edge1_valid", int'(valid_o), 0);
    @(posedge clk); #1 chk("lat_edge2_valid", int'(valid_o), 1);
    @(negedge clk); en = 1'b0;
    repeat (4) @(negedge clk);

    do_clr(); run(16'h0100, 16'h0000, 3'd0, 260);
    chk("sin_0", int'(cap[0]), 8'h00);
    chk("sin_1", int'(cap[1]), 8'h02);
    chk("sin_2", int'(cap[2]), 8'h03);
    chk("sin_3", int'(cap[3]), 8'h05);
    chk("sin_32", int'(cap[32]), 8'h2D);
    chk("sin_64", int'(cap[64]), 8'h40);
    chk("sin_192", int'(cap[192]), 8'hC0);
    chk("sin_255", int'(cap[255]), 8'hFE);
    chk("sin_256", int'(cap[256]), 8'h00);
    chk("sin_257", int'(cap[257]), 8'h02);

    do_clr(); run(16'h0100, 16'h0000, 3'd1, 10);
    chk("cos_0", int'(cap[0]), 8'h40);
    chk("cos_8", int'(cap[8]), 8'h3F);
    do_clr(); run(16'h0100, 16'h4000, 3'd0, 10);
    chk("off_0", int'(cap[0]), 8'h40);
    chk("off_8", int'(cap[8]), 8'h3F);

    do_clr(); run(16'h0100, 16'h0000, 3'd2, 170);
    chk("tri_32", int'(cap[32]), 8'h20);
    chk("tri_96", int'(cap[96]), 8'h20);
    chk("tri_160", int'(cap[160]), 8'hE0);
    do_clr(); run(16'h0100, 16'h0000, 3'd3, 130);
    chk("saw_0", int'(cap[0]), 8'h00);
    chk("saw_127", int'(cap[127]), 8'h3F);
    chk("saw_128", int'(cap[128]), 8'hC0);
    do_clr(); run(16'h0100, 16'h0000, 3'd4, 130);
    chk("sqr_127", int'(cap[127]), 8'h40);
    chk("sqr_128", int'(cap[128]), 8'hC0);
    do_clr(); run(16'h0100, 16'h0000, 3'd6, 4);
    chk("mode6_0", int'(cap[0]), 8'h00);

    do_clr(); run(16'hFF00, 16'h0000, 3'd0, 1);
    chk("wrap_phase", int'(phase_o), 16'hFF00);
    chk("wrap_0", int'(cap[0]), 8'h00);
    run(16'hFF00, 16'h0000, 3'd0, 3);
    chk("wrap_1", int'(cap[0]), 8'hFE);
    chk("wrap_2", int'(cap[1]), 8'hFD);
    chk("wrap_3", int'(cap[2]), 8'hFB);
    chk("wrap_phase_end", int'(phase_o), 16'hFC00);

    do_clr();
    ftw = 16'h0100; phase_off = 16'h0000; mode = 3'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); en = pat[i][0];
      @(posedge clk); #1;
      chk("gap_valid", int'(valid_o), expv[i]);
      if (i == 1) chk("gap_phase_hold", int'(phase_o), 16'h0100);
      if (i == 2) chk("gap_phase_adv", int'(phase_o), 16'h0200);
    end
    @(negedge clk); en = 1'b0;

    do_clr();
    @(negedge clk); ftw = 16'h0100; mode = 3'd0; en = 1'b1;
    repeat (10) @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_valid", int'(valid_o), 0);
    chk("clr_phase", int'(phase_o), 0);
    @(negedge clk); clr = 1'b0;
    found = 0;
    for (int k = 0; k < 6 && found == 0; k++) begin
      @(posedge clk); #1;
      if (valid_o) found = 1;
    end
    chk("clr_next_found", found, 1);
    chk("clr_next_sample", int'(sample_o), 8'h00);
    @(negedge clk); en = 1'b0;
    repeat (4) @(negedge clk);

    @(negedge clk); ftw = 16'($urandom); mode = 3'd2; en = 1'b1;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sample", int'(sample_o), 0);
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_phase", int'(phase_o), 0);
    @(posedge clk); #1;
    chk("midrst_hold_valid", int'(valid_o), 0);
    chk("midrst_hold_phase", int'(phase_o), 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);

    repeat (400) begin
      @(negedge clk);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) ftw = 16'($urandom);
      if ($urandom_range(0, 7) == 0) phase_off = 16'($urandom);
      if ($urandom_range(0, 5) == 0) mode = 3'($urandom_range(0, 7));
    end
    en = 1'b0;
    clr = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
